// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: control-bit positions and default widths.
package mem_stage_pkg;

   localparam int WORD_SIZE = 32;
   localparam int REG_SIZE  = 5;
   localparam int ADDR_BITS = 8;

   // Bit positions inside {Branch, MemRead, MemWrite}
   localparam int MC_BRANCH   = 2;
   localparam int MC_MEMREAD  = 1;
   localparam int MC_MEMWRITE = 0;

   // Bit positions inside {RegWrite, MemtoReg}
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   function automatic logic misaligned(
      input logic [1:0] lsb,
      input logic       rd,
      input logic       wr
   );
      return (rd | wr) & (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous write, no reset.
module mem_stage_data_memory
   import mem_stage_pkg::*;
#(
   parameter int word_size = WORD_SIZE,
   parameter int addr_bits = ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [addr_bits-1:0] addr_i,
   input  logic [word_size-1:0] wdata_i,
   output logic [word_size-1:0] rdata_o
);

   logic [word_size-1:0] mem_q [0:(2**addr_bits)-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read-during-write returns the old word
   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, branch resolution, data memory access, MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int word_size = WORD_SIZE,
   parameter int reg_size  = REG_SIZE,
   parameter int addr_bits = ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 flush,
   input  logic [word_size-1:0] alu_result,
   input  logic                 zero,
   input  logic [word_size-1:0] AddResult,
   input  logic [word_size-1:0] WriteData,
   input  logic [reg_size-1:0]  destination_reg,
   input  logic [2:0]           mem_control_signals,
   input  logic [1:0]           wb_control_signals,
   output logic                 PCSrc,
   output logic [word_size-1:0] branch_target,
   output logic [word_size-1:0] ReadData_wb,
   output logic [word_size-1:0] alu_result_wb,
   output logic [reg_size-1:0]  destination_reg_wb,
   output logic [1:0]           wb_control_signals_out,
   output logic                 misalign_wb
);

   logic [word_size-1:0] alu_q;
   logic [word_size-1:0] add_q;
   logic [word_size-1:0] wdata_q;
   logic                 zero_q;
   logic [reg_size-1:0]  dst_q;
   logic [2:0]           mc_q;
   logic [1:0]           wbc_q;

   logic [word_size-1:0] rd_wb_q;
   logic [word_size-1:0] alu_wb_q;
   logic [reg_size-1:0]  dst_wb_q;
   logic                 regwrite_wb_q;
   logic                 memtoreg_wb_q;
   logic                 mis_wb_q;

   logic                 branch;
   logic                 mem_rd;
   logic                 mem_wr;
   logic                 mis;
   logic                 we;
   logic [addr_bits-1:0] idx;
   logic [word_size-1:0] rdata;
   logic [word_size-1:0] ld_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_q   <= '0;
         add_q   <= '0;
         wdata_q <= '0;
         zero_q  <= 1'b0;
         dst_q   <= '0;
         mc_q    <= '0;
         wbc_q   <= '0;
      end else if (flush) begin
         alu_q   <= '0;
         add_q   <= '0;
         wdata_q <= '0;
         zero_q  <= 1'b0;
         dst_q   <= '0;
         mc_q    <= '0;
         wbc_q   <= '0;
      end else if (en) begin
         alu_q   <= alu_result;
         add_q   <= AddResult;
         wdata_q <= WriteData;
         zero_q  <= zero;
         dst_q   <= destination_reg;
         mc_q    <= mem_control_signals;
         wbc_q   <= wb_control_signals;
      end
   end

   assign branch        = mc_q[MC_BRANCH];
   assign mem_rd        = mc_q[MC_MEMREAD];
   assign mem_wr        = mc_q[MC_MEMWRITE];
   assign PCSrc         = branch & zero_q;
   assign branch_target = add_q;

   // Upper address bits are dropped, so addresses wrap modulo the depth
   assign idx = alu_q[addr_bits+1:2];
   assign mis = misaligned(alu_q[1:0], mem_rd, mem_wr);
   assign we  = mem_wr & en & ~mis;

   mem_stage_data_memory #(
      .word_size (word_size),
      .addr_bits (addr_bits)
   ) u_dmem (
      .clk     (clk),
      .we_i    (we),
      .addr_i  (idx),
      .wdata_i (wdata_q),
      .rdata_o (rdata)
   );

   assign ld_d = (mem_rd & ~mis) ? rdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_wb_q       <= '0;
         alu_wb_q      <= '0;
         dst_wb_q      <= '0;
         regwrite_wb_q <= 1'b0;
         memtoreg_wb_q <= 1'b0;
         mis_wb_q      <= 1'b0;
      end else if (en) begin
         rd_wb_q       <= ld_d;
         alu_wb_q      <= alu_q;
         dst_wb_q      <= dst_q;
         regwrite_wb_q <= wbc_q[WB_REGWRITE];
         memtoreg_wb_q <= wbc_q[WB_MEMTOREG];
         mis_wb_q      <= mis;
      end
   end

   assign ReadData_wb            = rd_wb_q;
   assign alu_result_wb          = alu_wb_q;
   assign destination_reg_wb     = dst_wb_q;
   assign wb_control_signals_out = {regwrite_wb_q, memtoreg_wb_q};
   assign misalign_wb            = mis_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus stall, flush and reset sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        flush;
   logic [31:0] alu_result;
   logic        zero;
   logic [31:0] AddResult;
   logic [31:0] WriteData;
   logic [4:0]  destination_reg;
   logic [2:0]  mem_control_signals;
   logic [1:0]  wb_control_signals;
   logic        PCSrc;
   logic [31:0] branch_target;
   logic [31:0] ReadData_wb;
   logic [31:0] alu_result_wb;
   logic [4:0]  destination_reg_wb;
   logic [1:0]  wb_control_signals_out;
   logic        misalign_wb;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage dut (
      .clk                    (clk),
      .reset                  (reset),
      .en                     (en),
      .flush                  (flush),
      .alu_result             (alu_result),
      .zero                   (zero),
      .AddResult              (AddResult),
      .WriteData              (WriteData),
      .destination_reg        (destination_reg),
      .mem_control_signals    (mem_control_signals),
      .wb_control_signals     (wb_control_signals),
      .PCSrc                  (PCSrc),
      .branch_target          (branch_target),
      .ReadData_wb            (ReadData_wb),
      .alu_result_wb          (alu_result_wb),
      .destination_reg_wb     (destination_reg_wb),
      .wb_control_signals_out (wb_control_signals_out),
      .misalign_wb            (misalign_wb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic        z;
      logic [31:0] add;
      logic [31:0] wd;
      logic [4:0]  dst;
      logic [2:0]  mc;
      logic [1:0]  wbc;
      logic        e_pc;
      logic [31:0] e_rd;
      logic        e_mis;
   } vec_t;

   vec_t tv [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic z, input logic [31:0] ad,
                        input logic [31:0] w, input logic [4:0] d,
                        input logic [2:0] m, input logic [1:0] b);
      alu_result          = a;
      zero                = z;
      AddResult           = ad;
      WriteData           = w;
      destination_reg     = d;
      mem_control_signals = m;
      wb_control_signals  = b;
   endtask

   task automatic nop();
      drive(32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".PCSrc"}, {31'b0, PCSrc}, 32'h0);
      chk({tag, ".bt"}, branch_target, 32'h0);
      chk({tag, ".rd_wb"}, ReadData_wb, 32'h0);
      chk({tag, ".alu_wb"}, alu_result_wb, 32'h0);
      chk({tag, ".dst_wb"}, {27'b0, destination_reg_wb}, 32'h0);
      chk({tag, ".wbc"}, {30'b0, wb_control_signals_out}, 32'h0);
      chk({tag, ".mis"}, {31'b0, misalign_wb}, 32'h0);
   endtask

   initial begin
      tv[0]  = '{32'h10,  1'b0, 32'h0,  32'hDEADBEEF, 5'd0,  3'b001, 2'b00, 1'b0, 32'h0,        1'b0};
      tv[1]  = '{32'h10,  1'b0, 32'h0,  32'h0,        5'd5,  3'b010, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0};
      tv[2]  = '{32'h0,   1'b1, 32'h40, 32'h0,        5'd0,  3'b100, 2'b00, 1'b1, 32'h0,        1'b0};
      tv[3]  = '{32'h0,   1'b0, 32'h44, 32'h0,        5'd0,  3'b100, 2'b00, 1'b0, 32'h0,        1'b0};
      tv[4]  = '{32'h13,  1'b0, 32'h0,  32'h12345678, 5'd0,  3'b001, 2'b00, 1'b0, 32'h0,        1'b1};
      tv[5]  = '{32'h10,  1'b0, 32'h0,  32'h0,        5'd6,  3'b010, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0};
      tv[6]  = '{32'h02,  1'b0, 32'h0,  32'h0,        5'd7,  3'b010, 2'b11, 1'b0, 32'h0,        1'b1};
      tv[7]  = '{32'h400, 1'b0, 32'h0,  32'hCAFEF00D, 5'd0,  3'b001, 2'b00, 1'b0, 32'h0,        1'b0};
      tv[8]  = '{32'h0,   1'b0, 32'h0,  32'h0,        5'd8,  3'b010, 2'b11, 1'b0, 32'hCAFEF00D, 1'b0};
      tv[9]  = '{32'h400, 1'b0, 32'h0,  32'h0,        5'd9,  3'b010, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0};
      tv[10] = '{32'h20,  1'b0, 32'h0,  32'hAAAA5555, 5'd0,  3'b001, 2'b00, 1'b0, 32'h0,        1'b0};
      tv[11] = '{32'h20,  1'b0, 32'h0,  32'h11111111, 5'd10, 3'b011, 2'b10, 1'b0, 32'hAAAA5555, 1'b0};
      tv[12] = '{32'h20,  1'b0, 32'h0,  32'h0,        5'd11, 3'b010, 2'b11, 1'b0, 32'h11111111, 1'b0};
      tv[13] = '{32'h7,   1'b1, 32'h80, 32'h0,        5'd12, 3'b000, 2'b10, 1'b0, 32'h0,        1'b0};

      reset = 1'b1;
      en    = 1'b1;
      flush = 1'b0;
      nop();
      #12;
      chk_all_zero("reset0");
      @(negedge clk);
      reset = 1'b0;
      step();

      // Vector i enters EX/MEM at step i; its WB results appear at step i+1
      for (int i = 0; i <= 14; i++) begin
         if (i < 14) begin
            drive(tv[i].alu, tv[i].z, tv[i].add, tv[i].wd, tv[i].dst, tv[i].mc, tv[i].wbc);
         end else begin
            nop();
         end
         step();
         if (i < 14) begin
            chk($sformatf("v%0d.PCSrc", i), {31'b0, PCSrc}, {31'b0, tv[i].e_pc});
            chk($sformatf("v%0d.bt", i), branch_target, tv[i].add);
         end
         if (i > 0) begin
            chk($sformatf("v%0d.rd_wb", i-1), ReadData_wb, tv[i-1].e_rd);
            chk($sformatf("v%0d.alu_wb", i-1), alu_result_wb, tv[i-1].alu);
            chk($sformatf("v%0d.dst_wb", i-1), {27'b0, destination_reg_wb}, {27'b0, tv[i-1].dst});
            chk($sformatf("v%0d.wbc", i-1), {30'b0, wb_control_signals_out}, {30'b0, tv[i-1].wbc});
            chk($sformatf("v%0d.mis", i-1), {31'b0, misalign_wb}, {31'b0, tv[i-1].e_mis});
         end
      end

      // Asynchronous reset with both pipeline registers loaded
      drive(32'h5C, 1'b1, 32'h40, 32'h0, 5'd3, 3'b100, 2'b11);
      step();
      step();
      chk("pre_rst.PCSrc", {31'b0, PCSrc}, 32'h1);
      chk("pre_rst.alu_wb", alu_result_wb, 32'h5C);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("midrst");
      #2;
      reset = 1'b0;
      nop();
      step();

      // Stalled store: only one write, using the data held in EX/MEM
      drive(32'h08, 1'b0, 32'h0, 32'h01010101, 5'd0, 3'b001, 2'b00);
      step();
      nop();
      step();
      chk("seed.mem2", dut.u_dmem.mem_q[2], 32'h01010101);
      drive(32'h08, 1'b0, 32'h0, 32'h77777777, 5'd0, 3'b001, 2'b00);
      step();
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         WriteData = 32'h88888888 + k;
         step();
         chk($sformatf("stall%0d.mem2", k), dut.u_dmem.mem_q[2], 32'h01010101);
      end
      en = 1'b1;
      drive(32'h08, 1'b0, 32'h0, 32'h0, 5'd4, 3'b010, 2'b11);
      step();
      chk("unstall.mem2", dut.u_dmem.mem_q[2], 32'h77777777);
      chk("unstall.alu_wb", alu_result_wb, 32'h08);
      nop();
      step();
      chk("unstall.rd_wb", ReadData_wb, 32'h77777777);
      chk("unstall.dst_wb", {27'b0, destination_reg_wb}, 32'd4);

      // Flush while stalled turns the pending store into a bubble
      drive(32'h08, 1'b0, 32'h0, 32'h99999999, 5'd0, 3'b001, 2'b00);
      step();
      en    = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      en    = 1'b1;
      nop();
      step();
      step();
      chk("flush.mem2", dut.u_dmem.mem_q[2], 32'h77777777);
      chk("flush.mis", {31'b0, misalign_wb}, 32'h0);

      // Flush clears a resolved branch
      drive(32'h0, 1'b1, 32'h60, 32'h0, 5'd0, 3'b100, 2'b00);
      step();
      chk("br.PCSrc", {31'b0, PCSrc}, 32'h1);
      chk("br.bt", branch_target, 32'h60);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("brflush.PCSrc", {31'b0, PCSrc}, 32'h0);
      chk("brflush.bt", branch_target, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
